shift_exec_unit: RTL and testbench
==================================

# shift_exec_unit

Iterative shift execution unit on the datapath side of the multicycle arithmetic processor. The control unit issues a one-cycle start command carrying the operand, shift type and shift amount. This block then performs the shift one bit per cycle and returns a one-cycle done pulse. With the done pulse it returns a held result and zero/negative flags, so the control unit sequences shift instructions by handshake rather than by counting cycles itself.

## Interface
- WIDTH, 16, datapath word width in bits
- CNT_W, 6, width of the shift-amount field
- CLK  input  1  clock, all state updates on rising edge
- RST_N  input  1  synchronous, active-low reset
- START  input  1  command strobe, sampled only in IDLE
- OP  input  2  00 SLL, 01 SRL, 10 SRA, 11 PASS (no shift)
- DIN  input  WIDTH  operand, captured with START
- SHAMT  input  CNT_W  shift amount, captured with START
- BUSY  output  1  high whenever state is not IDLE
- DONE  output  1  one-cycle pulse, result and flags valid
- DOUT  output  WIDTH  result register
- Z_FLAG  output  1  DOUT == 0, updated when DONE is asserted
- N_FLAG  output  1  DOUT[WIDTH-1], updated when DONE is asserted

## Operation
- States:
  - IDLE
  - SHIFT
  - FIN (DONE asserted)
- IDLE:
  - On START=1, capture DIN into the accumulator, OP into the op register, and n = min(SHAMT, WIDTH) into the counter.
  - n == 0 or OP == PASS -> FIN.
  - Otherwise -> SHIFT.
- SHIFT: each cycle, shift the accumulator by one bit and decrement the counter.
  - SLL: shift left, fill with 0.
  - SRL: shift right, fill with 0.
  - SRA: shift right, fill with the accumulator MSB.
  - When the counter goes 1 -> 0 in this cycle, go to FIN.
- FIN:
  - DONE=1 for exactly one cycle.
  - DOUT, Z_FLAG and N_FLAG are registered from the final accumulator on entry to FIN.
  - Next state is IDLE.
- DOUT and the flags hold their values until the next FIN, and do not change during SHIFT.
- START is ignored while BUSY=1, including the FIN cycle. A command is never queued.
- SHAMT >= WIDTH is clamped to WIDTH iterations:
  - SLL and SRL give 0.
  - SRA gives all bits equal to the operand sign.
- PASS returns DIN unchanged; SHAMT is ignored.
- OP, DIN and SHAMT are don't-care when START=0 or BUSY=1.

## Timing
- Reset (RST_N low at a rising edge):
  - state IDLE, BUSY=0, DONE=0, DOUT=0, Z_FLAG=0, N_FLAG=0, counter=0.
- Reset takes priority over START and aborts any shift in progress. No DONE is produced for an aborted command.
- Latency: START high in cycle t gives DONE high in cycle t+1+n, where n is the clamped shift count (0 for PASS).
- BUSY is high from cycle t+1 through the DONE cycle inclusive, then low.
- Earliest back-to-back command: START in the cycle after DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SHIFT_FAST_EN defined:
  - IDLE with START goes directly to FIN.
  - The result is computed by a single-cycle barrel shifter with the same clamp and fill rules.
  - DONE occurs in cycle t+1 for every SHAMT.
  - SHIFT state and counter are not synthesised.
- SHIFT_FAST_EN undefined: iterative one-bit-per-cycle behaviour as described above. This is the default, chosen for minimum area.
- The result values, flags, handshake and reset behaviour are identical in both builds; only latency differs.

## Test plan
- SLL: START in cycle t with DIN=0x0001, SHAMT=4 -> BUSY high t+1..t+5, DONE in t+5 only, DOUT=0x0010, Z=0, N=0.
- SRA: DIN=0x8000, SHAMT=3 -> DONE in t+4, DOUT=0xF000, N=1, Z=0.
- SRL clamp: DIN=0x8000, SHAMT=20 -> DONE in t+17, DOUT=0x0000, Z=1. Repeat as SRA with DIN=0x8000 -> DOUT=0xFFFF, N=1.
- Zero shift: SLL with DIN=0x1234, SHAMT=0 -> DONE in t+1, DOUT=0x1234. Repeat with PASS and SHAMT=9 -> same result.
- Busy and abort:
  - Pulse START at t+2 during a SHAMT=5 shift -> ignored, single DONE in t+6, result from the first command.
  - RST_N low in cycle t+3 of a new command -> next cycle IDLE, all outputs 0, no DONE.
  - A following START with DIN=0x0003, SRL, SHAMT=1 -> DOUT=0x0001.
- SHIFT_FAST_EN build: SLL with DIN=0x00FF, SHAMT=8 -> DONE in t+1, DOUT=0xFF00, N=1. Rerun all of the above for identical values with latency 1.

Source files
------------

// File: rtl/shift_exec_unit.sv
// Shift execution unit: one-bit-per-cycle SLL/SRL/SRA/PASS with a START/DONE handshake and held
// result/flags. Define SHIFT_FAST_EN to replace the iteration with a single-cycle barrel shifter.
module shift_exec_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] DIN,
  input  logic [CNT_W-1:0] SHAMT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DOUT,
  output logic             Z_FLAG,
  output logic             N_FLAG
);

  localparam logic [1:0] OpSll  = 2'b00;
  localparam logic [1:0] OpSrl  = 2'b01;
  localparam logic [1:0] OpSra  = 2'b10;
  localparam logic [1:0] OpPass = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] dout_q;
  logic             z_q;
  logic             n_q;

  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] start_res;
  logic             start_fin;

  // Shift counts beyond the word width saturate at WIDTH iterations.
  assign amt = (SHAMT > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : SHAMT;

`ifdef SHIFT_FAST_EN
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] a, input logic [1:0] op,
                                              input logic [CNT_W-1:0] n);
    logic [WIDTH-1:0] r;
    r = a;
    case (op)
      OpSll:   r = a << n;
      OpSrl:   r = a >> n;
      OpSra:   r = $signed(a) >>> n;
      default: r = a;
    endcase
    return r;
  endfunction

  assign start_res = barrel(DIN, OP, amt);
  assign start_fin = 1'b1;
`else
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_step;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] a, input logic [1:0] op);
    logic [WIDTH-1:0] r;
    r = a;
    case (op)
      OpSll:   r = {a[WIDTH-2:0], 1'b0};
      OpSrl:   r = {1'b0, a[WIDTH-1:1]};
      OpSra:   r = {a[WIDTH-1], a[WIDTH-1:1]};
      default: r = a;
    endcase
    return r;
  endfunction

  assign acc_step  = step(acc_q, op_q);
  assign start_res = DIN;
  assign start_fin = (amt == '0) || (OP == OpPass);
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      dout_q  <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`ifndef SHIFT_FAST_EN
      acc_q   <= '0;
      op_q    <= OpSll;
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
`ifndef SHIFT_FAST_EN
            acc_q <= DIN;
            op_q  <= OP;
            cnt_q <= amt;
`endif
            if (start_fin) begin
              state_q <= StFin;
              dout_q  <= start_res;
              z_q     <= (start_res == '0);
              n_q     <= start_res[WIDTH-1];
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
`ifdef SHIFT_FAST_EN
          state_q <= StIdle;
`else
          acc_q <= acc_step;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StFin;
            dout_q  <= acc_step;
            z_q     <= (acc_step == '0);
            n_q     <= acc_step[WIDTH-1];
          end
`endif
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign BUSY   = (state_q != StIdle);
  assign DONE   = (state_q == StFin);
  assign DOUT   = dout_q;
  assign Z_FLAG = z_q;
  assign N_FLAG = n_q;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Bench for shift_exec_unit: arithmetic reference model checked every cycle, plus directed
// commands with hand-computed results and latencies.
module tb_shift_exec_unit;

`ifdef SHIFT_FAST_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  localparam logic [1:0] SLL  = 2'b00;
  localparam logic [1:0] SRL  = 2'b01;
  localparam logic [1:0] SRA  = 2'b10;
  localparam logic [1:0] PASS = 2'b11;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic [15:0] DIN = 16'h0;
  logic [5:0]  SHAMT = 6'd0;
  logic        BUSY, DONE, Z_FLAG, N_FLAG;
  logic [15:0] DOUT;

  int checks = 0;
  int errors = 0;

  shift_exec_unit #(.WIDTH(16), .CNT_W(6)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .DIN(DIN), .SHAMT(SHAMT),
    .BUSY(BUSY), .DONE(DONE), .DOUT(DOUT), .Z_FLAG(Z_FLAG), .N_FLAG(N_FLAG)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer shifts on a clamped count.
  function automatic int ref_n(input logic [1:0] op, input logic [5:0] sh);
    if (op == PASS) return 0;
    return (int'(sh) > 16) ? 16 : int'(sh);
  endfunction

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] op,
                                            input logic [5:0] sh);
    int n;
    int s;
    n = ref_n(op, sh);
    s = int'($signed(d));
    case (op)
      SLL:     return 16'((32'(d) << n));
      SRL:     return 16'((32'(d) >> n));
      SRA:     return 16'((s >>> n));
      default: return d;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [5:0] sh);
    return Fast ? 1 : 1 + ref_n(op, sh);
  endfunction

  // Model state: a pending command completes after its latency in edges.
  bit          m_init = 1'b0;
  logic        m_pend, m_busy, m_done, m_z, m_n;
  logic [15:0] m_res, m_dout;
  int          m_wait;

  always @(posedge CLK) begin : model
    logic [15:0] r;
    int          w;
    logic        p;
    logic        d;
    if (!RST_N) begin
      m_init <= 1'b1;
      m_pend <= 1'b0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_z    <= 1'b0;
      m_n    <= 1'b0;
      m_res  <= 16'h0;
      m_dout <= 16'h0;
      m_wait <= 0;
    end else if (m_init) begin
      r = m_res;
      w = m_wait;
      p = m_pend;
      d = 1'b0;
      if (!m_busy && START) begin
        r = ref_shift(DIN, OP, SHAMT);
        w = ref_lat(OP, SHAMT);
        p = 1'b1;
      end
      if (p) begin
        w = w - 1;
        if (w == 0) begin
          p = 1'b0;
          d = 1'b1;
        end
      end
      m_res  <= r;
      m_wait <= w;
      m_pend <= p;
      m_done <= d;
      m_busy <= p || d;
      if (d) begin
        m_dout <= r;
        m_z    <= (r == 16'h0);
        m_n    <= r[15];
      end
    end
  end

  always @(negedge CLK) begin
    if (m_init) begin
      chk("model_busy", 32'(BUSY), 32'(m_busy));
      chk("model_done", 32'(DONE), 32'(m_done));
      chk("model_dout", 32'(DOUT), 32'(m_dout));
      chk("model_z", 32'(Z_FLAG), 32'(m_z));
      chk("model_n", 32'(N_FLAG), 32'(m_n));
    end
  end

  // Issue one command; optionally pulse a conflicting START in cycle t+intr.
  task automatic run_cmd(input string nm, input logic [15:0] din, input logic [1:0] op,
                         input logic [5:0] sh, input logic [15:0] exp_d, input int lat_it,
                         input int intr);
    int first;
    int exp_lat;
    exp_lat = Fast ? 1 : lat_it;
    first = 0;
    @(posedge CLK); #1;
    START = 1'b1; DIN = din; OP = op; SHAMT = sh;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      START = (k == intr);
      if (k == intr) begin
        DIN = 16'hFFFF; OP = SRL; SHAMT = 6'd1;
      end
      @(negedge CLK);
      if (DONE) begin
        first = k;
        break;
      end
    end
    if (START) begin
      @(posedge CLK); #1;
      START = 1'b0;
    end
    if (first == 0) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout actual=no DONE expected=DONE in cycle t+%0d", nm, exp_lat);
    end else begin
      chk({nm, "_lat"}, 32'(first), 32'(exp_lat));
      chk({nm, "_dout"}, 32'(DOUT), 32'(exp_d));
      chk({nm, "_z"}, 32'(Z_FLAG), 32'(exp_d == 16'h0));
      chk({nm, "_n"}, 32'(N_FLAG), 32'(exp_d[15]));
    end
  endtask

  initial begin
    int ndone;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_zn", {30'd0, Z_FLAG, N_FLAG}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    run_cmd("sll4", 16'h0001, SLL, 6'd4, 16'h0010, 5, 0);
    run_cmd("sra3", 16'h8000, SRA, 6'd3, 16'hF000, 4, 0);
    run_cmd("srl20", 16'h8000, SRL, 6'd20, 16'h0000, 17, 0);
    run_cmd("sra20", 16'h8000, SRA, 6'd20, 16'hFFFF, 17, 0);
    run_cmd("sll0", 16'h1234, SLL, 6'd0, 16'h1234, 1, 0);
    run_cmd("pass9", 16'h1234, PASS, 6'd9, 16'h1234, 1, 0);
    run_cmd("sll8", 16'h00FF, SLL, 6'd8, 16'hFF00, 9, 0);
    run_cmd("srl4", 16'h00F0, SRL, 6'd4, 16'h000F, 5, 0);
    run_cmd("sll16", 16'hFFFF, SLL, 6'd16, 16'h0000, 17, 0);
    run_cmd("sra_pos", 16'h4000, SRA, 6'd63, 16'h0000, 17, 0);
    run_cmd("pass0", 16'h0000, PASS, 6'd2, 16'h0000, 1, 0);
    // Conflicting START while busy (in the FIN cycle for the single-cycle build).
    run_cmd("busy", 16'h0003, SLL, 6'd5, 16'h0060, 6, Fast ? 1 : 2);

    // Abort: reset in cycle t+3 of a long command.
    @(posedge CLK); #1;
    START = 1'b1; DIN = 16'hABCD; OP = SRL; SHAMT = 6'd10;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_dout", 32'(DOUT), 32'd0);
    chk("abort_zn", {30'd0, Z_FLAG, N_FLAG}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    run_cmd("srl1", 16'h0003, SRL, 6'd1, 16'h0001, 2, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
